mem_line_responder: RTL
=======================

// Module: mem_line_responder
// PURPOSE
// - Main-memory side of cache bus 2 (A2/D2/C2): answers READ_LINE/WRITE_LINE from the cache controller.
// - Holds a line-addressed backing RAM; adds fixed access latency; bursts a line over D2 in DATA2_W beats.
// - Sits between cache_cpu's bus-2 master port and the top-level bus-2 wires.
// - Replaces the behavioural memory model with a clocked responder.
// PARAMETERS
// - ADDR2_W      14   line-address width (tag+set), A2 width
// - DATA2_W      16   D2 width, bits per beat
// - LINE_BYTES   16   cache line size; BEATS = LINE_BYTES*8/DATA2_W (default 8)
// - MEM_LATENCY  100  cycles from command cycle to first response cycle; must be >= BEATS
// - C2_W         2    C2 width
// PORTS
// - CLK      in   1        clock, all state on rising edge
// - RESET    in   1        asynchronous, active-high reset
// - A2       in   ADDR2_W  line address, valid in command cycle only
// - C2_in    in   C2_W     command from cache: 0 NOP, 1 RESPONSE (ignored), 2 READ_LINE, 3 WRITE_LINE
// - D2_in    in   DATA2_W  write beats from cache
// - C2_out   out  C2_W     0 NOP, 1 RESPONSE
// - C2_oe    out  1        responder drives C2
// - D2_out   out  DATA2_W  read beats
// - D2_oe    out  1        responder drives D2
// BEHAVIOUR
// - Reset: state IDLE, counters 0, C2_out=0, C2_oe=0, D2_out=0, D2_oe=0. RAM contents not touched by reset.
// - RAM: 2^ADDR2_W lines x BEATS words. Sim init: word i of line a = {a[7:0], i[7:0]} zero-extended/truncated to DATA2_W.
// - Cycle 0 = cycle in which a command is sampled in IDLE. Beat 0 = lowest-addressed word of the line.
// - FSM: IDLE, WR_RECV, WAIT, RD_SEND, WR_ACK.
// - IDLE: C2_in=2 -> latch A2 -> WAIT(read). C2_in=3 -> latch A2, store D2_in as beat 0 -> WR_RECV.
//   C2_in=0/1 -> stay.
// - WR_RECV: store D2_in as beats 1..BEATS-1 on cycles 1..BEATS-1 into a line buffer.
//   After the last beat: commit the buffer to RAM in one write -> WAIT(write).
// - WAIT: latency counter; leaves at the end of cycle MEM_LATENCY-1 -> RD_SEND or WR_ACK.
// - RD_SEND: cycles MEM_LATENCY..MEM_LATENCY+BEATS-1: C2_oe=1, C2_out=1, D2_oe=1, D2_out=beat k. Then -> IDLE.
// - WR_ACK: cycle MEM_LATENCY only: C2_oe=1, C2_out=1, D2_oe=0. Then -> IDLE.
// - Outputs are registered; they are valid during the cycle they are stated for.
// - After a response, both oe drop the next cycle.
//   A new command is accepted in that same first IDLE cycle (no turnaround gap).
// - Commands while not IDLE: ignored; no error and no queueing.
// - Beat counter 0..BEATS-1, no wrap; latency counter 0..MEM_LATENCY-1, width $clog2(MEM_LATENCY+1).
// - RESET mid-operation:
//   - Abort immediately and release the bus (oe=0).
//   - Partial write in WR_RECV: buffer discarded, RAM unchanged.
//   - Write already committed (WAIT/WR_ACK): RAM keeps the new data.
// - Read and write to the same line back-to-back: the read returns the committed write data.
// CONFIGURATION
// - MEM_STATS_EN defined:
//   - Adds ports rd_count out 16 and wr_count out 16.
//   - Incremented on entry to RD_SEND / WR_ACK; saturate at 16'hFFFF; reset to 0.
// - MEM_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
// - Read after reset: C2_in=2, A2=5 in cycle 0 (MEM_LATENCY=100, DATA2_W=16).
//   -> C2 silent cycles 1..99; cycles 100..107 C2_out=1, D2_out=16'h0500..16'h0507; oe=0 at 108.
// - Write then read: WRITE_LINE A2=9, beats 16'hA000..A007 in cycles 0..7 -> single RESPONSE at cycle 100.
//   Then READ_LINE A2=9 at cycle 101 -> D2_out=16'hA000..A007 at cycles 201..208.
// - Busy ignore: READ_LINE A2=3, then WRITE_LINE A2=4 at cycle 50.
//   -> only the read response (16'h0300..) appears; line 4 unchanged on a later read (16'h0400..).
// - Reset mid-write: RESET pulse at cycle 4 of WRITE_LINE A2=7 -> all oe=0 at once.
//   A later read of line 7 returns 16'h0700..0707.
// - NOP/RESPONSE on C2_in in IDLE for 20 cycles -> no state change, oe stay 0.
// - MEM_STATS_EN: 2 reads + 1 write -> rd_count=2, wr_count=1; RESET -> both 0.

Source files
------------

// File: rtl/mem_line_responder_if.sv
// Cache bus 2 (A2/D2/C2) between the cache controller (master) and main memory (slave).
interface mem_line_responder_if #(
  parameter int unsigned ADDR2_W = 14,
  parameter int unsigned DATA2_W = 16,
  parameter int unsigned C2_W    = 2
);
  logic [ADDR2_W-1:0] A2;
  logic [C2_W-1:0]    C2_in;
  logic [DATA2_W-1:0] D2_in;
  logic [C2_W-1:0]    C2_out;
  logic               C2_oe;
  logic [DATA2_W-1:0] D2_out;
  logic               D2_oe;

  modport master (
    output A2, C2_in, D2_in,
    input  C2_out, C2_oe, D2_out, D2_oe
  );

  modport slave (
    input  A2, C2_in, D2_in,
    output C2_out, C2_oe, D2_out, D2_oe
  );
endinterface

// File: rtl/mem_line_responder.sv
// Main-memory responder on cache bus 2: line-addressed RAM, fixed access latency,
// reads burst out in BEATS beats, writes are collected then committed as one line.
// Optional: define MEM_STATS_EN to add saturating rd_count/wr_count ports.
// The array holds data XOR its power-up image, so an all-zero array reads back as
// word i of line a = {a[7:0], i[7:0]}; reset never touches the array.
module mem_line_responder #(
  parameter int unsigned ADDR2_W     = 14,
  parameter int unsigned DATA2_W     = 16,
  parameter int unsigned LINE_BYTES  = 16,
  parameter int unsigned MEM_LATENCY = 100,
  parameter int unsigned C2_W        = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  mem_line_responder_if.slave    bus
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
`endif
);

  localparam int unsigned BEATS  = LINE_BYTES * 8 / DATA2_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LAT_W  = $clog2(MEM_LATENCY + 1);
  localparam int unsigned LINE_W = BEATS * DATA2_W;
  localparam int unsigned LINES  = 2 ** ADDR2_W;

  localparam logic [C2_W-1:0] CMD_READ  = C2_W'(2);
  localparam logic [C2_W-1:0] CMD_WRITE = C2_W'(3);
  localparam logic [C2_W-1:0] RSP_NOP   = C2_W'(0);
  localparam logic [C2_W-1:0] RSP_RESP  = C2_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_WR_RECV, S_WAIT, S_RD_SEND, S_WR_ACK} state_e;

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR2_W-1:0]  addr_q, addr_d;
  logic                is_wr_q, is_wr_d;
  logic [DATA2_W-1:0]  buf_q [BEATS];
  logic [DATA2_W-1:0]  buf_d [BEATS];
  logic                commit_c;
  logic [LINE_W-1:0]   wr_line_c;
  logic [LINE_W-1:0]   rd_line_c;
  logic [LINE_W-1:0]   ram_q [LINES];

  logic [C2_W-1:0]     c2_out_q, c2_out_d;
  logic                c2_oe_q, c2_oe_d;
  logic [DATA2_W-1:0]  d2_out_q, d2_out_d;
  logic                d2_oe_q, d2_oe_d;

  // Power-up image of one line: word i = {line[7:0], i[7:0]} fitted to DATA2_W.
  function automatic logic [LINE_W-1:0] init_line(input logic [ADDR2_W-1:0] a);
    logic [LINE_W-1:0] l;
    logic [15:0]       w;
    l = '0;
    for (int i = 0; i < int'(BEATS); i++) begin
      w = {8'(a), 8'(i)};
      l[i*DATA2_W +: DATA2_W] = DATA2_W'(w);
    end
    return l;
  endfunction

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus latency/beat counters and write-line assembly.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    is_wr_d  = is_wr_q;
    buf_d    = buf_q;
    commit_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.C2_in == CMD_READ) begin
          addr_d  = bus.A2;
          is_wr_d = 1'b0;
          beat_d  = '0;
          lat_d   = (MEM_LATENCY == 1) ? LAT_W'(0) : LAT_W'(1);
          state_d = (MEM_LATENCY == 1) ? S_RD_SEND : S_WAIT;
        end else if (bus.C2_in == CMD_WRITE) begin
          addr_d   = bus.A2;
          is_wr_d  = 1'b1;
          buf_d[0] = bus.D2_in;
          beat_d   = BEAT_W'(1);
          lat_d    = LAT_W'(1);
          state_d  = S_WR_RECV;
        end
      end
      S_WR_RECV: begin
        buf_d[beat_q] = bus.D2_in;
        lat_d         = lat_q + LAT_W'(1);
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          commit_c = 1'b1;
          beat_d   = '0;
          // Latency equal to the burst length leaves no WAIT cycles.
          if (lat_q == LAT_W'(MEM_LATENCY - 1)) begin
            lat_d   = '0;
            state_d = S_WR_ACK;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_W'(MEM_LATENCY - 1)) begin
          lat_d   = '0;
          beat_d  = '0;
          state_d = is_wr_q ? S_WR_ACK : S_RD_SEND;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_RD_SEND: begin
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          beat_d  = '0;
          state_d = S_IDLE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_WR_ACK: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bus outputs for the coming cycle, decoded from the next state.
  always_comb begin
    c2_out_d  = RSP_NOP;
    c2_oe_d   = 1'b0;
    d2_out_d  = '0;
    d2_oe_d   = 1'b0;
    rd_line_c = ram_q[addr_d] ^ init_line(addr_d);
    if (state_d == S_RD_SEND || state_d == S_WR_ACK) begin
      c2_out_d = RSP_RESP;
      c2_oe_d  = 1'b1;
    end
    if (state_d == S_RD_SEND) begin
      d2_oe_d  = 1'b1;
      d2_out_d = rd_line_c[int'(beat_d)*DATA2_W +: DATA2_W];
    end
  end

  // Flatten the line buffer (last beat already merged) for the single commit.
  always_comb begin
    wr_line_c = '0;
    for (int i = 0; i < int'(BEATS); i++) wr_line_c[i*DATA2_W +: DATA2_W] = buf_d[i];
  end

  // Counters, latched command and registered bus outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lat_q    <= '0;
      beat_q   <= '0;
      addr_q   <= '0;
      is_wr_q  <= 1'b0;
      for (int i = 0; i < int'(BEATS); i++) buf_q[i] <= '0;
      c2_out_q <= RSP_NOP;
      c2_oe_q  <= 1'b0;
      d2_out_q <= '0;
      d2_oe_q  <= 1'b0;
    end else begin
      lat_q    <= lat_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      is_wr_q  <= is_wr_d;
      buf_q    <= buf_d;
      c2_out_q <= c2_out_d;
      c2_oe_q  <= c2_oe_d;
      d2_out_q <= d2_out_d;
      d2_oe_q  <= d2_oe_d;
    end
  end

  // Backing array: one full-line write when the last write beat arrives.
  always_ff @(posedge CLK) begin
    if (commit_c) ram_q[addr_q] <= wr_line_c ^ init_line(addr_q);
  end

  assign bus.C2_out = c2_out_q;
  assign bus.C2_oe  = c2_oe_q;
  assign bus.D2_out = d2_out_q;
  assign bus.D2_oe  = d2_oe_q;

`ifdef MEM_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  // Saturating counts of response phases entered.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (state_d == S_RD_SEND && state_q != S_RD_SEND && rd_count_q != 16'hFFFF)
      rd_count_d = rd_count_q + 16'd1;
    if (state_d == S_WR_ACK && state_q != S_WR_ACK && wr_count_q != 16'hFFFF)
      wr_count_d = wr_count_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule
